rvm_fu_sched: RTL and testbench

Multi-cycle scheduler that sequences one ALU-class instruction through the core datapath: GPR read, dispatch to the selected functional unit (adder, bitwise or shifter), wait for unit valid, GPR write-back. Sits between the decode stage and the `rvm_gprs` / functional-unit instances in `rvm_core`. It is the only driver of the GPR read/write ports and the shared functional-unit operand bus.

---
 rtl/rvm_fu_sched_pkg.sv | 33 +++
 rtl/rvm_fu_sched_fu_mux.sv | 38 +++
 rtl/rvm_fu_sched.sv | 162 ++++++++++++++++
 tb/tb_rvm_fu_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvm_fu_sched_pkg.sv
// Shared types for the ALU-class instruction scheduler: unit select codes,
// FSM states and the latched request record.
package rvm_fu_sched_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FU_ADD = 2'b00,
    FU_BIT = 2'b01,
    FU_SHF = 2'b10,
    FU_ILL = 2'b11
  } fu_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_ERR
  } state_e;

  typedef struct packed {
    fu_e              fu;
    logic [1:0]       op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic             use_imm;
    logic [XLEN-1:0]  imm;
  } req_t;

endpackage

// File: rtl/rvm_fu_sched_fu_mux.sv
// Selects the valid/result pair of the functional unit named by the
// instruction; bitwise and shift results are zero-extended to 33 bits.
module rvm_fu_sched_fu_mux
  import rvm_fu_sched_pkg::*;
(
  input  fu_e             fu_i,
  input  logic            add_valid_i,
  input  logic [XLEN:0]   add_result_i,
  input  logic            bit_valid_i,
  input  logic [XLEN-1:0] bit_result_i,
  input  logic            shf_valid_i,
  input  logic [XLEN-1:0] shf_result_i,
  output logic            valid_o,
  output logic [XLEN:0]   result_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    valid_o  = 1'b0;
    result_o = '0;
    case (fu_i)
      FU_ADD: begin
        valid_o  = add_valid_i;
        result_o = add_result_i;
      end
      FU_BIT: begin
        valid_o  = bit_valid_i;
        result_o = {1'b0, bit_result_i};
      end
      FU_SHF: begin
        valid_o  = shf_valid_i;
        result_o = {1'b0, shf_result_i};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvm_fu_sched.sv
// Sequences one ALU-class instruction: GPR read, dispatch to the selected
// unit, bounded wait for its valid, then GPR write-back or abort.
module rvm_fu_sched
  import rvm_fu_sched_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_fu_i,
  input  logic [1:0]        req_op_i,
  input  logic [REG_AW-1:0] req_rs1_i,
  input  logic [REG_AW-1:0] req_rs2_i,
  input  logic [REG_AW-1:0] req_rd_i,
  input  logic              req_use_imm_i,
  input  logic [XLEN-1:0]   req_imm_i,
  output logic              rs1_en_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  input  logic [XLEN-1:0]   rs1_rdata_i,
  output logic              rs2_en_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs2_rdata_i,
  output logic              rd_wen_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]   rd_wdata_o,
  output logic [XLEN-1:0]   fu_lhs_o,
  output logic [XLEN-1:0]   fu_rhs_o,
  output logic [1:0]        fu_op_o,
  input  logic              add_valid_i,
  input  logic [XLEN:0]     add_result_i,
  input  logic              bit_valid_i,
  input  logic [XLEN-1:0]   bit_result_i,
  input  logic              shf_valid_i,
  input  logic [XLEN-1:0]   shf_result_i,
  output logic              done_o,
  output logic [XLEN:0]     result_o,
  output logic              err_o
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  state_e          state_q, state_d;
  req_t            req_q;
  logic [XLEN-1:0] lhs_q, rhs_q;
  logic [7:0]      cnt_q;
  logic [XLEN:0]   res_q;
  logic            sel_valid;
  logic [XLEN:0]   sel_result;
  logic            accept;
  logic            req_illegal;

  assign accept      = (state_q == ST_IDLE) && req_valid_i;
  assign req_illegal = (fu_e'(req_fu_i) == FU_ILL);

  rvm_fu_sched_fu_mux u_fu_mux (
    .fu_i         (req_q.fu),
    .add_valid_i  (add_valid_i),
    .add_result_i (add_result_i),
    .bit_valid_i  (bit_valid_i),
    .bit_result_i (bit_result_i),
    .shf_valid_i  (shf_valid_i),
    .shf_result_i (shf_result_i),
    .valid_o      (sel_valid),
    .result_o     (sel_result)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid_i) state_d = req_illegal ? ST_ERR : ST_READ;
      ST_READ: state_d = ST_EXEC;
      // A valid seen on the last permitted cycle still wins over the timeout.
      ST_EXEC: begin
        if (sel_valid)              state_d = ST_WB;
        else if (cnt_q == CNT_LAST) state_d = ST_ERR;
      end
      ST_WB, ST_ERR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_q <= '0;
      lhs_q <= '0;
      rhs_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        req_q.fu      <= fu_e'(req_fu_i);
        req_q.op      <= req_op_i;
        req_q.rs1     <= req_rs1_i;
        req_q.rs2     <= req_rs2_i;
        req_q.rd      <= req_rd_i;
        req_q.use_imm <= req_use_imm_i;
        req_q.imm     <= req_imm_i;
      end
      if (state_q == ST_READ) begin
        lhs_q <= rs1_rdata_i;
        rhs_q <= req_q.use_imm ? req_q.imm : rs2_rdata_i;
        cnt_q <= '0;
      end
      // res_q doubles as the retired result, so an abort leaves it untouched.
      if (state_q == ST_EXEC) begin
        if (sel_valid) res_q <= sel_result;
        else           cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    rs1_en_o    = 1'b0;
    rs1_addr_o  = '0;
    rs2_en_o    = 1'b0;
    rs2_addr_o  = '0;
    rd_wen_o    = 1'b0;
    rd_addr_o   = '0;
    rd_wdata_o  = '0;
    fu_lhs_o    = '0;
    fu_rhs_o    = '0;
    fu_op_o     = '0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i && !req_illegal) begin
          rs1_en_o   = 1'b1;
          rs1_addr_o = req_rs1_i;
          rs2_en_o   = !req_use_imm_i;
          rs2_addr_o = req_use_imm_i ? '0 : req_rs2_i;
        end
      end
      ST_EXEC: begin
        fu_lhs_o = lhs_q;
        fu_rhs_o = rhs_q;
        fu_op_o  = req_q.op;
      end
      ST_WB: begin
        rd_wen_o   = (req_q.rd != '0);
        rd_addr_o  = req_q.rd;
        rd_wdata_o = res_q[XLEN-1:0];
        done_o     = 1'b1;
      end
      ST_ERR: err_o = 1'b1;
      default: ;
    endcase
  end

  assign result_o = res_q;

endmodule

// File: tb/tb_rvm_fu_sched.sv
// Self-checking bench for rvm_fu_sched: directed vector table, a reset
// sequence and randomized instructions against a register-file model.
`timescale 1ns/1ps
module tb_rvm_fu_sched;
  import rvm_fu_sched_pkg::*;

  localparam int unsigned MAX_WAIT = 15;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready;
  logic [1:0] req_fu, req_op;
  logic [4:0] req_rs1, req_rs2, req_rd;
  logic req_use_imm;
  logic [31:0] req_imm;
  logic rs1_en, rs2_en, rd_wen;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
  logic [31:0] fu_lhs, fu_rhs;
  logic [1:0] fu_op;
  logic add_valid, bit_valid, shf_valid;
  logic [32:0] add_result;
  logic [31:0] bit_result, shf_result;
  logic done, err;
  logic [32:0] result;

  rvm_fu_sched #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_fu_i(req_fu), .req_op_i(req_op),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_rd_i(req_rd),
    .req_use_imm_i(req_use_imm), .req_imm_i(req_imm),
    .rs1_en_o(rs1_en), .rs1_addr_o(rs1_addr), .rs1_rdata_i(rs1_rdata),
    .rs2_en_o(rs2_en), .rs2_addr_o(rs2_addr), .rs2_rdata_i(rs2_rdata),
    .rd_wen_o(rd_wen), .rd_addr_o(rd_addr), .rd_wdata_o(rd_wdata),
    .fu_lhs_o(fu_lhs), .fu_rhs_o(fu_rhs), .fu_op_o(fu_op),
    .add_valid_i(add_valid), .add_result_i(add_result),
    .bit_valid_i(bit_valid), .bit_result_i(bit_result),
    .shf_valid_i(shf_valid), .shf_result_i(shf_result),
    .done_o(done), .result_o(result), .err_o(err)
  );

  always #5 clk = ~clk;

  // Behaviour of the three functional units as seen by the scheduler.
  function automatic logic [32:0] fu_model(input logic [1:0] fu, input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [5:0]  s;
    s = {1'b0, b[4:0]};
    r = '0;
    case (fu)
      2'b00: return {1'b0, a} + {1'b0, b};
      2'b01: case (op)
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = a & ~b;
      endcase
      2'b10: case (op)
        2'd0:    r = a << s;
        2'd1:    r = a >> s;
        2'd2:    r = $signed(a) >>> s;
        default: r = (a << s) | (a >> (6'd32 - s));
      endcase
      default: r = '0;
    endcase
    return {1'b0, r};
  endfunction

  logic [32:0] bit_full, shf_full;
  assign add_result = fu_model(2'b00, fu_op, fu_lhs, fu_rhs);
  assign bit_full   = fu_model(2'b01, fu_op, fu_lhs, fu_rhs);
  assign shf_full   = fu_model(2'b10, fu_op, fu_lhs, fu_rhs);
  assign bit_result = bit_full[31:0];
  assign shf_result = shf_full[31:0];

  // Register file environment: one-cycle read latency, x0 hardwired to zero.
  logic [31:0] gpr [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (rs1_en) rs1_rdata <= (rs1_addr == 5'd0) ? 32'd0 : gpr[rs1_addr];
    if (rs2_en) rs2_rdata <= (rs2_addr == 5'd0) ? 32'd0 : gpr[rs2_addr];
    if (pl_en) gpr[pl_addr] <= pl_data;
    else if (rd_wen && rd_addr != 5'd0) gpr[rd_addr] <= rd_wdata;
  end

  logic [31:0] mdl [32];
  logic [32:0] last_res;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  fu;
    logic [1:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm;
    logic [31:0] imm;
    int          lat;      // EXEC cycles before the unit raises valid; >= MAX_WAIT means never
    bit          auto_exp; // expectations come from the model instead of the table
    logic [32:0] exp_res;
    bit          exp_err;
    int          exp_cyc;  // cycles from the accept cycle to done/err
  } vec_t;

  function automatic vec_t mk(input logic [1:0] fu, input logic [1:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic use_imm,
                              input logic [31:0] imm, input int lat, input logic [32:0] exp_res,
                              input bit exp_err, input int exp_cyc);
    vec_t v;
    v.fu = fu; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.use_imm = use_imm; v.imm = imm; v.lat = lat; v.auto_exp = 1'b0;
    v.exp_res = exp_res; v.exp_err = exp_err; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  task automatic preload_all(input logic [31:0] vals [32]);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 5'(i);
      pl_data = (i == 0) ? 32'd0 : vals[i];
      mdl[i]  = (i == 0) ? 32'd0 : vals[i];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_units(input logic [1:0] fu, input bit sel);
    add_valid = (fu == 2'b00) ? sel : 1'($urandom);
    bit_valid = (fu == 2'b01) ? sel : 1'($urandom);
    shf_valid = (fu == 2'b10) ? sel : 1'($urandom);
  endtask

  task automatic run(input vec_t vin);
    vec_t v;
    int ev_cyc;
    bit ev_err, stray, opnd_bad;
    logic [31:0] exp_lhs, exp_rhs, got_wdata;
    logic [32:0] got_res;
    logic [4:0]  got_addr;
    logic        got_wen;
    v = vin;
    ev_cyc = -1; ev_err = 1'b0; stray = 1'b0; opnd_bad = 1'b0;
    got_res = '0; got_wen = 1'b0; got_addr = '0; got_wdata = '0;
    exp_lhs = mdl[v.rs1];
    exp_rhs = v.use_imm ? v.imm : mdl[v.rs2];
    if (v.auto_exp) begin
      if (v.fu == 2'b11) begin
        v.exp_err = 1'b1; v.exp_cyc = 1; v.exp_res = last_res;
      end else if (v.lat >= int'(MAX_WAIT)) begin
        v.exp_err = 1'b1; v.exp_cyc = 2 + int'(MAX_WAIT); v.exp_res = last_res;
      end else begin
        v.exp_err = 1'b0; v.exp_cyc = 3 + v.lat;
        v.exp_res = fu_model(v.fu, v.op, exp_lhs, exp_rhs);
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_fu = v.fu; req_op = v.op; req_rs1 = v.rs1; req_rs2 = v.rs2;
    req_rd = v.rd; req_use_imm = v.use_imm; req_imm = v.imm;
    drive_units(2'b11, 1'b0);
    #1;
    check("ready_at_accept", req_ready, 1);
    check("rs1_port", {rs1_en, rs1_addr}, (v.fu == 2'b11) ? 6'd0 : {1'b1, v.rs1});
    check("rs2_port", {rs2_en, rs2_addr}, (v.fu == 2'b11 || v.use_imm) ? 6'd0 : {1'b1, v.rs2});

    for (int k = 1; k < 40 && ev_cyc < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_fu = 2'($urandom); req_op = 2'($urandom); req_rs1 = 5'($urandom);
      req_rs2 = 5'($urandom); req_rd = 5'($urandom); req_use_imm = 1'($urandom);
      req_imm = $urandom;
      drive_units(v.fu, (v.lat < int'(MAX_WAIT)) && (k >= 2 + v.lat));
      #1;
      if (done || err) begin
        ev_cyc = k; ev_err = err; got_res = result;
        got_wen = rd_wen; got_addr = rd_addr; got_wdata = rd_wdata;
        if (done && err) stray = 1'b1;
      end else if (rd_wen) stray = 1'b1;
      if (rs1_en || rs2_en || req_ready) stray = 1'b1;
      if (ev_cyc < 0 && k >= 2 && v.fu != 2'b11) begin
        if (fu_lhs !== exp_lhs || fu_rhs !== exp_rhs || fu_op !== v.op) opnd_bad = 1'b1;
      end else if (fu_lhs != '0 || fu_rhs != '0 || fu_op != '0) stray = 1'b1;
    end

    check("event_cycle", 64'(ev_cyc), 64'(v.exp_cyc));
    check("event_is_err", ev_err, v.exp_err);
    check("busy_outputs_quiet", stray, 0);
    if (v.fu != 2'b11) check("fu_operands", opnd_bad, 0);
    if (!v.exp_err) begin
      check("result", got_res, v.exp_res);
      check("writeback", {got_wen, got_addr, got_wdata}, {v.rd != 5'd0, v.rd, v.exp_res[31:0]});
      if (v.rd != 5'd0) mdl[v.rd] = v.exp_res[31:0];
      last_res = v.exp_res;
    end else begin
      check("err_result_held", got_res, last_res);
      check("err_no_write", got_wen, 0);
    end
  endtask

  vec_t tbl [10];
  logic [31:0] init_vals [32];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_fu = '0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; req_use_imm = 1'b0; req_imm = '0;
    add_valid = 1'b0; bit_valid = 1'b0; shf_valid = 1'b0;
    last_res = '0;
    for (int i = 0; i < 32; i++) init_vals[i] = 32'd0;
    init_vals[1] = 32'd5; init_vals[2] = 32'd7; init_vals[10] = 32'hFFFF_FFFF;

    // fu, op, rs1, rs2, rd, use_imm, imm, lat, exp_res, exp_err, exp_cyc
    tbl[0] = mk(2'b00, 2'd0, 5'd1,  5'd2, 5'd3,  1'b0, 32'd0, 0,  33'h0_0000_000C, 1'b0, 3);
    tbl[1] = mk(2'b00, 2'd0, 5'd1,  5'd2, 5'd5,  1'b0, 32'd0, 0,  33'h0_0000_000C, 1'b0, 3);
    tbl[2] = mk(2'b01, 2'd0, 5'd5,  5'd1, 5'd6,  1'b0, 32'd0, 0,  33'h0_0000_0004, 1'b0, 3);
    tbl[3] = mk(2'b10, 2'd0, 5'd1,  5'd2, 5'd7,  1'b0, 32'd0, 4,  33'h0_0000_0280, 1'b0, 7);
    tbl[4] = mk(2'b00, 2'd0, 5'd1,  5'd2, 5'd8,  1'b0, 32'd0, 15, 33'h0_0000_0280, 1'b1, 17);
    tbl[5] = mk(2'b11, 2'd0, 5'd1,  5'd2, 5'd9,  1'b0, 32'd0, 0,  33'h0_0000_0280, 1'b1, 1);
    tbl[6] = mk(2'b01, 2'd1, 5'd1,  5'd2, 5'd0,  1'b0, 32'd0, 0,  33'h0_0000_0007, 1'b0, 3);
    tbl[7] = mk(2'b01, 2'd2, 5'd1,  5'd2, 5'd9,  1'b0, 32'd0, 14, 33'h0_0000_0002, 1'b0, 17);
    tbl[8] = mk(2'b00, 2'd0, 5'd10, 5'd2, 5'd4,  1'b1, 32'd1, 0,  33'h1_0000_0000, 1'b0, 3);
    tbl[9] = mk(2'b10, 2'd2, 5'd10, 5'd2, 5'd11, 1'b1, 32'd4, 0,  33'h0_FFFF_FFFF, 1'b0, 3);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", req_ready, 1);
    check("reset_outputs", {done, err, rd_wen, rs1_en, rs2_en, fu_lhs, fu_op}, 0);
    check("reset_result", result, 0);

    preload_all(init_vals);
    for (int i = 0; i < 10; i++) run(tbl[i]);

    // Reset while the instruction sits in EXEC waiting on its unit.
    @(negedge clk);
    req_valid = 1'b1; req_fu = 2'b00; req_op = 2'd0; req_rs1 = 5'd1; req_rs2 = 5'd2;
    req_rd = 5'd12; req_use_imm = 1'b0; req_imm = '0;
    drive_units(2'b00, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("exec_before_reset", fu_lhs, 32'd5);
    #1;
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", {done, err, rd_wen, rs1_en, rs2_en, fu_lhs, fu_rhs, fu_op}, 0);
    check("reset_mid_result", result, 0);
    last_res = '0;
    @(negedge clk);
    reset = 1'b0;
    drive_units(2'b00, 1'b1);
    #1;
    check("ready_after_reset", req_ready, 1);
    repeat (3) @(negedge clk);
    #1;
    check("no_retire_after_reset", {done, err, rd_wen}, 0);

    for (int i = 0; i < 32; i++) init_vals[i] = $urandom;
    preload_all(init_vals);
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int r;
      v = mk(2'b00, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 0, '0, 1'b0, 0);
      v.auto_exp = 1'b1;
      v.fu = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v.op = 2'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.rd = 5'($urandom);
      v.use_imm = 1'($urandom); v.imm = $urandom;
      r = $urandom_range(0, 9);
      v.lat = (r < 6) ? r % 3 : (r == 6) ? 13 : (r == 7) ? 14 : (r == 8) ? 15 : 0;
      run(v);
    end

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) check($sformatf("gpr_x%0d", i), gpr[i], mdl[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
